// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: paces audio sampling and reads one 16-bit frame from a 12-bit SPI ADC per tick.
// Define ADC_OFFSET_REMOVE_EN to deliver DC-centred two's complement samples instead of raw codes.
module adc_spi_sampler #(
  parameter int SCLK_DIV   = 4,
  parameter int SAMPLE_DIV = 12500,
  parameter int FRAME_BITS = 16,
  parameter int DATA_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              adc_miso,
  output logic              adc_sclk,
  output logic              adc_cs_n,
  output logic [DATA_W-1:0] adc_data,
  output logic              adc_valid,
  output logic              overrun
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [DIV_W-1:0]    div_cnt;
  logic                div_last;
  logic [BIT_W-1:0]    bit_cnt;
  logic                bit_last;
  logic [DATA_W-1:0]   shift;
  logic [DATA_W-1:0]   sample_word;

  assign tick     = enable && (tick_cnt == TICK_W'(SAMPLE_DIV - 1));
  assign div_last = (div_cnt == DIV_W'(SCLK_DIV - 1));
  assign bit_last = (bit_cnt == BIT_W'(FRAME_BITS - 1));

  // Only the last DATA_W bits of the frame are kept; the leading zeros fall off the top.
`ifdef ADC_OFFSET_REMOVE_EN
  assign sample_word = {~shift[DATA_W-1], shift[DATA_W-2:0]};
`else
  assign sample_word = shift;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // NOTE: the shift register is a handful of flops, not a memory, so it is reset with the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b1;
      adc_data  <= '0;
      adc_valid <= 1'b0;
      overrun   <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
    end else begin
      adc_valid <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            div_cnt  <= '0;
          end
        end
        SETUP: begin
          if (div_last) begin
            state    <= SHIFT;
            adc_sclk <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!div_last) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!adc_sclk) begin
              // The ADC changes MISO on the falling edge, so it is stable at the rising one.
              adc_sclk <= 1'b1;
              shift    <= {shift[DATA_W-2:0], adc_miso};
            end else if (bit_last) begin
              state     <= DONE;
              adc_cs_n  <= 1'b1;
              adc_valid <= 1'b1;
              adc_data  <= sample_word;
            end else begin
              adc_sclk <= 1'b0;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: two instances (stream pacing and overrun pacing) against an ADC model
// and a frame-level reference of expected samples, latencies and strobe spacing.
module tb_adc_spi_sampler;

  localparam int SCLK_DIV   = 4;
  localparam int FRAME_BITS = 16;
  localparam int DATA_W     = 12;
  localparam int DIV_A      = 200;
  localparam int DIV_B      = 100;
  localparam int LAT        = SCLK_DIV * (1 + 2 * FRAME_BITS);
  localparam logic [11:0] SAMPLE_B = 12'h3C7;
`ifdef ADC_OFFSET_REMOVE_EN
  localparam logic [11:0] SINGLE_EXP = 12'h25C;
`else
  localparam logic [11:0] SINGLE_EXP = 12'hA5C;
`endif

  typedef struct {
    int          cyc;
    int          lat;
    int          rises;
    logic [11:0] data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rst_a = 1'b0, en_a = 1'b1, miso_a = 1'b0;
  logic sclk_a, cs_a, valid_a, ovr_a;
  logic [DATA_W-1:0] data_a;
  logic rst_b = 1'b0, en_b = 1'b0, miso_b = 1'b0;
  logic sclk_b, cs_b, valid_b, ovr_b;
  logic [DATA_W-1:0] data_b;

  adc_spi_sampler #(.SCLK_DIV(SCLK_DIV), .SAMPLE_DIV(DIV_A), .FRAME_BITS(FRAME_BITS), .DATA_W(DATA_W))
    u_dut (.clk(clk), .rst(rst_a), .enable(en_a), .adc_miso(miso_a), .adc_sclk(sclk_a),
           .adc_cs_n(cs_a), .adc_data(data_a), .adc_valid(valid_a), .overrun(ovr_a));

  adc_spi_sampler #(.SCLK_DIV(SCLK_DIV), .SAMPLE_DIV(DIV_B), .FRAME_BITS(FRAME_BITS), .DATA_W(DATA_W))
    u_ovr (.clk(clk), .rst(rst_b), .enable(en_b), .adc_miso(miso_b), .adc_sclk(sclk_b),
           .adc_cs_n(cs_b), .adc_data(data_b), .adc_valid(valid_b), .overrun(ovr_b));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: raw code, or the code minus mid-scale wrapped to DATA_W bits.
  function automatic logic [11:0] expect_word(input logic [11:0] raw);
`ifdef ADC_OFFSET_REMOVE_EN
    return 12'((int'(raw) - 2048 + 4096) % 4096);
`else
    return raw;
`endif
  endfunction

  // ADC model A: a new word per chip-select fall, one bit per SCLK falling edge, MSB first.
  logic [11:0] stim_q[$];
  logic [11:0] exp_q[$];
  logic [15:0] word_a;
  int          idx_a;
  always @(negedge cs_a) begin
    logic [11:0] s;
    logic [3:0]  lead;
    if (stim_q.size() > 0) begin
      s    = stim_q.pop_front();
      lead = 4'h0;
    end else begin
      s    = 12'($urandom);
      lead = 4'($urandom);
    end
    exp_q.push_back(expect_word(s));
    word_a = {lead, s};
    idx_a  = 15;
  end
  always @(negedge sclk_a) if (cs_a === 1'b0) begin
    miso_a = word_a[idx_a];
    idx_a--;
  end

  logic [15:0] word_b;
  int          idx_b;
  always @(negedge cs_b) begin
    word_b = {4'h0, SAMPLE_B};
    idx_b  = 15;
  end
  always @(negedge sclk_b) if (cs_b === 1'b0) begin
    miso_b = word_b[idx_b];
    idx_b--;
  end

  // Monitor A: per-frame chip-select fall time, SCLK rising edges, strobe time and data.
  ev_t  ev_q[$];
  int   cs_fall_cyc_a = 0, rises_a = 0, n_csfall_a = 0, dbl_valid_a = 0;
  logic prev_cs_a = 1'b1, prev_sclk_a = 1'b1, prev_valid_a = 1'b0;
  always @(negedge clk) begin
    if (prev_cs_a === 1'b1 && cs_a === 1'b0) begin
      cs_fall_cyc_a = cyc;
      rises_a = 0;
      n_csfall_a++;
    end
    if (cs_a === 1'b0 && prev_sclk_a === 1'b0 && sclk_a === 1'b1) rises_a++;
    if (valid_a === 1'b1) begin
      if (prev_valid_a === 1'b1) dbl_valid_a++;
      ev_q.push_back('{cyc: cyc, lat: cyc - cs_fall_cyc_a, rises: rises_a, data: data_a});
    end
    prev_cs_a    = cs_a;
    prev_sclk_a  = sclk_a;
    prev_valid_a = valid_a;
  end

  // Monitor B: lat holds the number of cycles chip select stayed low for the frame.
  ev_t  evb_q[$];
  int   cs_low_b = 0, rises_b = 0, n_csfall_b = 0, ovr_drop_b = 0;
  logic prev_cs_b = 1'b1, prev_sclk_b = 1'b1, prev_ovr_b = 1'b0;
  always @(negedge clk) begin
    if (prev_cs_b === 1'b1 && cs_b === 1'b0) begin
      cs_low_b = 0;
      rises_b = 0;
      n_csfall_b++;
    end
    if (cs_b === 1'b0) cs_low_b++;
    if (cs_b === 1'b0 && prev_sclk_b === 1'b0 && sclk_b === 1'b1) rises_b++;
    if (valid_b === 1'b1) evb_q.push_back('{cyc: cyc, lat: cs_low_b, rises: rises_b, data: data_b});
    if (prev_ovr_b === 1'b1 && ovr_b !== 1'b1) ovr_drop_b++;
    prev_cs_b   = cs_b;
    prev_sclk_b = sclk_b;
    prev_ovr_b  = ovr_b;
  end

  initial begin
    int base, csf, t_en, delta, nv;

    // Reset held with enable high and MISO toggling.
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      miso_a = 1'($urandom);
      check("reset_outputs", {cs_a, sclk_a, valid_a, ovr_a, data_a}, 16'hC000);
    end
    check("reset_no_cs_fall", n_csfall_a, 0);

    // Single frame 0x0A5C followed by a stream of 0x000, 0xFFF, 0x800.
    stim_q = '{12'hA5C, 12'h000, 12'hFFF, 12'h800};
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    for (int k = 0; k < 4 * DIV_A + 400 && ev_q.size() < 4; k++) @(posedge clk);
    check("stream_timeout", ev_q.size() >= 4, 1'b1);
    if (ev_q.size() > 0) check("single_data", ev_q[0].data, SINGLE_EXP);
    for (int i = 0; i < 4 && i < ev_q.size(); i++) begin
      check("frame_latency", ev_q[i].lat, LAT);
      check("frame_sclk_rises", ev_q[i].rises, FRAME_BITS);
      check("stream_data", ev_q[i].data, exp_q[i]);
      if (i > 0) check("stream_spacing", ev_q[i].cyc - ev_q[i-1].cyc, DIV_A);
    end
    @(negedge clk);
    check("data_held", data_a, exp_q[ev_q.size()-1]);
    check("stream_overrun", ovr_a, 1'b0);

    // Drop enable after 10 bits of the next frame.
    base = ev_q.size();
    for (int k = 0; k < DIV_A + 200 && !(cs_a === 1'b0 && rises_a >= 10); k++) @(posedge clk);
    check("ten_bits_timeout", rises_a >= 10, 1'b1);
    @(negedge clk);
    en_a = 1'b0;
    for (int k = 0; k < 400 && ev_q.size() <= base; k++) @(posedge clk);
    check("disable_valid_timeout", ev_q.size() > base, 1'b1);
    if (ev_q.size() > base) begin
      check("disable_rises", ev_q[base].rises, FRAME_BITS);
      check("disable_data", ev_q[base].data, exp_q[base]);
    end
    csf = n_csfall_a;
    repeat (3 * DIV_A + 20) @(posedge clk);
    check("disabled_no_cs_fall", n_csfall_a, csf);
    check("disabled_cs_high", cs_a, 1'b1);

    // Re-enable: chip select falls about SAMPLE_DIV clocks later.
    @(negedge clk);
    en_a = 1'b1;
    t_en = cyc;
    for (int k = 0; k < 2 * DIV_A && n_csfall_a == csf; k++) @(posedge clk);
    check("reenable_timeout", n_csfall_a > csf, 1'b1);
    delta = cs_fall_cyc_a - t_en;
    check("reenable_latency", delta >= DIV_A && delta <= DIV_A + 1, 1'b1);

    // Reset in the middle of SHIFT, after 7 bits.
    for (int k = 0; k < 200 && rises_a < 7; k++) @(posedge clk);
    check("seven_bits_timeout", rises_a >= 7, 1'b1);
    @(negedge clk);
    nv = ev_q.size();
    rst_a = 1'b0;
    #1;
    check("midreset_outputs", {cs_a, sclk_a, valid_a, ovr_a, data_a}, 16'hC000);
    exp_q.delete();
    repeat (20) @(posedge clk);
    check("midreset_no_valid", ev_q.size(), nv);
    ev_q.delete();
    stim_q.push_back(12'h3A7);
    @(negedge clk);
    rst_a = 1'b1;

    // One known sample, then randomized samples with random leading bits.
    for (int k = 0; k < 5 * DIV_A + 400 && ev_q.size() < 5; k++) @(posedge clk);
    check("random_timeout", ev_q.size() >= 5, 1'b1);
    if (ev_q.size() > 0) check("post_reset_data", ev_q[0].data, expect_word(12'h3A7));
    for (int i = 0; i < 5 && i < ev_q.size(); i++) begin
      check("rand_latency", ev_q[i].lat, LAT);
      check("rand_sclk_rises", ev_q[i].rises, FRAME_BITS);
      check("rand_data", ev_q[i].data, exp_q[i]);
      if (i > 0) check("rand_spacing", ev_q[i].cyc - ev_q[i-1].cyc, DIV_A);
    end
    check("a_overrun_clear", ovr_a, 1'b0);
    check("a_no_double_valid", dbl_valid_a, 0);

    // Overrun instance: every second tick lands mid-frame.
    check("b_overrun_idle", ovr_b, 1'b0);
    @(negedge clk);
    en_b = 1'b1;
    for (int k = 0; k < 6 * DIV_B + 400 && evb_q.size() < 4; k++) @(posedge clk);
    check("b_timeout", evb_q.size() >= 4, 1'b1);
    check("b_overrun_set", ovr_b, 1'b1);
    for (int i = 0; i < evb_q.size(); i++) begin
      check("b_cs_low_len", evb_q[i].lat, LAT);
      check("b_sclk_rises", evb_q[i].rises, FRAME_BITS);
      check("b_data", evb_q[i].data, expect_word(SAMPLE_B));
      if (i > 0) check("b_spacing_min", evb_q[i].cyc - evb_q[i-1].cyc >= LAT + 2, 1'b1);
    end
    @(negedge clk);
    en_b = 1'b0;
    repeat (3 * DIV_B) @(posedge clk);
    check("b_frames_complete", n_csfall_b, evb_q.size());
    check("b_overrun_sticky", ovr_b, 1'b1);
    check("b_overrun_never_cleared", ovr_drop_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
